// File: rtl/addsub_share_arbiter_if.sv
// Bundles the two request ports, the shared-adder hookup and the response buffer.
interface addsub_share_arbiter_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_sub;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_sub;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_issub;
  logic             add_cin;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;
  logic             add_ovfl;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_ovfl;
  logic             rsp_zero;

  logic [CNT_W-1:0] gnt_cnt0;
  logic [CNT_W-1:0] gnt_cnt1;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  add_s, add_cout, add_ovfl,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output add_a, add_b, add_issub, add_cin,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovfl, rsp_zero,
    output gnt_cnt0, gnt_cnt1
  );

  // Requesters, shared adder and response consumer side
  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output add_s, add_cout, add_ovfl,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  add_a, add_b, add_issub, add_cin,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovfl, rsp_zero,
    input  gnt_cnt0, gnt_cnt1
  );
endinterface

// File: rtl/addsub_share_arbiter.sv
// Round-robin share of one combinational add/sub unit between two requesters,
// with a single-entry registered response buffer and per-port grant counters.
module addsub_share_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input logic                   clk,
  input logic                   rst,
  addsub_share_arbiter_if.slave bus
);

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rsp_state_e       state_q, state_d;
  logic             last_gnt_q, last_gnt_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovfl_q, ovfl_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic slot_free;
  logic sel;
  logic accept;

  // Arbitration, handshake and shared-adder drive; port 0 wins when nothing contends
  always_comb begin
    slot_free = (state_q == RSP_EMPTY) || bus.rsp_ready;
    if (bus.req0_valid && bus.req1_valid) begin
      sel = ~last_gnt_q;
    end else begin
      sel = bus.req1_valid;
    end
    accept         = slot_free && (bus.req0_valid || bus.req1_valid);
    bus.req0_ready = slot_free && !(bus.req1_valid && sel);
    bus.req1_ready = slot_free && !(bus.req0_valid && !sel);

    bus.add_a     = '0;
    bus.add_b     = '0;
    bus.add_issub = 1'b0;
    bus.add_cin   = 1'b0;
    if (accept) begin
      bus.add_a     = sel ? bus.req1_a   : bus.req0_a;
      bus.add_b     = sel ? bus.req1_b   : bus.req0_b;
      bus.add_issub = sel ? bus.req1_sub : bus.req0_sub;
      bus.add_cin   = sel ? bus.req1_sub : bus.req0_sub;
    end
  end

  // Next state: capture on accept, drain when consumed, saturating grant counts
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    id_d       = id_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    ovfl_d     = ovfl_q;
    zero_d     = zero_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    if (accept) begin
      state_d    = RSP_FULL;
      last_gnt_d = sel;
      id_d       = sel;
      sum_d      = bus.add_s;
      cout_d     = bus.add_cout;
      ovfl_d     = bus.add_ovfl;
      zero_d     = (bus.add_s == '0);
      if (!sel && (cnt0_q != CNT_MAX)) begin
        cnt0_d = cnt0_q + CNT_W'(1);
      end
      if (sel && (cnt1_q != CNT_MAX)) begin
        cnt1_d = cnt1_q + CNT_W'(1);
      end
    end else if (bus.rsp_ready) begin
      state_d = RSP_EMPTY;
    end
  end

  // State register; reset discards any buffered result and favours port 0 next
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RSP_EMPTY;
      last_gnt_q <= 1'b1;
      id_q       <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovfl_q     <= 1'b0;
      zero_q     <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      id_q       <= id_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      ovfl_q     <= ovfl_d;
      zero_q     <= zero_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  // Response buffer and counters drive the outputs straight from flops
  assign bus.rsp_valid = (state_q == RSP_FULL);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
  assign bus.rsp_ovfl  = ovfl_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.gnt_cnt0  = cnt0_q;
  assign bus.gnt_cnt1  = cnt1_q;

endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Directed plus randomized bench for addsub_share_arbiter with an arithmetic reference model.
module tb_addsub_share_arbiter;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 8;
  localparam int MODV    = 1 << WIDTH;
  localparam int HALF    = MODV / 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  addsub_share_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  addsub_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shared carry-lookahead adder stand-in: inverts B on subtract, carries in add_cin
  logic [WIDTH-1:0] add_bx;
  logic [WIDTH:0]   add_t;
  always_comb begin
    add_bx       = bus.add_issub ? ~bus.add_b : bus.add_b;
    add_t        = {1'b0, bus.add_a} + {1'b0, add_bx} + {{WIDTH{1'b0}}, bus.add_cin};
    bus.add_s    = add_t[WIDTH-1:0];
    bus.add_cout = add_t[WIDTH];
    bus.add_ovfl = (bus.add_a[WIDTH-1] == add_bx[WIDTH-1]) &&
                   (add_t[WIDTH-1] != bus.add_a[WIDTH-1]);
  end

  int n_vec = 0;
  int n_bad = 0;

  // Reference model of the response buffer and fairness state
  int m_valid, m_id, m_sum, m_cout, m_ovfl, m_zero, m_last;
  int m_cnt [2];
  bit last_acc;
  int last_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid  = 0; m_id = 0; m_sum = 0; m_cout = 0; m_ovfl = 0; m_zero = 0;
    m_last   = 1;
    m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  // Plain integer arithmetic: unsigned carry/borrow and signed range overflow
  task automatic ref_op(input int a, input int b, input bit sub,
                        output int sum, output int cout, output int ovfl);
    int sa, sb, sr;
    sa = (a >= HALF) ? a - MODV : a;
    sb = (b >= HALF) ? b - MODV : b;
    if (sub) begin
      sum  = (a - b + MODV) % MODV;
      cout = (a >= b) ? 1 : 0;
      sr   = sa - sb;
    end else begin
      sum  = (a + b) % MODV;
      cout = (a + b >= MODV) ? 1 : 0;
      sr   = sa + sb;
    end
    ovfl = (sr >= HALF || sr < -HALF) ? 1 : 0;
  endtask

  task automatic drive(input bit v0, input int a0, input int b0, input bit s0,
                       input bit v1, input int a1, input int b1, input bit s1, input bit rr);
    bus.req0_valid = v0; bus.req0_a = WIDTH'(a0); bus.req0_b = WIDTH'(b0); bus.req0_sub = s0;
    bus.req1_valid = v1; bus.req1_a = WIDTH'(a1); bus.req1_b = WIDTH'(b1); bus.req1_sub = s1;
    bus.rsp_ready  = rr;
  endtask

  // One clock: drive at negedge, check handshake/adder drive, then registered state
  task automatic cycle(input bit v0, input int a0, input int b0, input bit s0,
                       input bit v1, input int a1, input int b1, input bit s1, input bit rr);
    bit slot, acc;
    int sel, ea, eb, es, r_sum, r_cout, r_ovfl;
    @(negedge clk);
    drive(v0, a0, b0, s0, v1, a1, b1, s1, rr);
    #1;
    slot = (m_valid == 0) || rr;
    if (v0 && v1)  sel = 1 - m_last;
    else if (v1)   sel = 1;
    else           sel = 0;
    acc = slot && (v0 || v1);
    if (v0) chk("req0_ready", 32'(bus.req0_ready), 32'(acc && sel == 0));
    if (v1) chk("req1_ready", 32'(bus.req1_ready), 32'(acc && sel == 1));
    if (acc) begin
      ea = (sel == 1) ? a1 : a0;
      eb = (sel == 1) ? b1 : b0;
      es = (sel == 1) ? int'(s1) : int'(s0);
    end else begin
      ea = 0; eb = 0; es = 0;
    end
    chk("add_a",     32'(bus.add_a),     32'(ea));
    chk("add_b",     32'(bus.add_b),     32'(eb));
    chk("add_issub", 32'(bus.add_issub), 32'(es));
    chk("add_cin",   32'(bus.add_cin),   32'(es));
    @(posedge clk);
    #1;
    if (acc) begin
      ref_op(ea, eb, es[0], r_sum, r_cout, r_ovfl);
      m_valid = 1; m_id = sel; m_last = sel;
      m_sum = r_sum; m_cout = r_cout; m_ovfl = r_ovfl; m_zero = (r_sum == 0) ? 1 : 0;
      if (m_cnt[sel] < CNT_MAX) m_cnt[sel]++;
    end else if (rr) begin
      m_valid = 0;
    end
    last_acc = acc;
    last_sel = sel;
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
    if (m_valid != 0) begin
      chk("rsp_id",   32'(bus.rsp_id),   32'(m_id));
      chk("rsp_sum",  32'(bus.rsp_sum),  32'(m_sum));
      chk("rsp_cout", 32'(bus.rsp_cout), 32'(m_cout));
      chk("rsp_ovfl", 32'(bus.rsp_ovfl), 32'(m_ovfl));
      chk("rsp_zero", 32'(bus.rsp_zero), 32'(m_zero));
    end
    chk("gnt_cnt0", 32'(bus.gnt_cnt0), 32'(m_cnt[0]));
    chk("gnt_cnt1", 32'(bus.gnt_cnt1), 32'(m_cnt[1]));
  endtask

  initial begin
    bit pend0, pend1, v0, v1, s0, s1, rr;
    int a0, b0, a1, b1;
    int exp_ids [4];

    // Reset state
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
    chk("rst_rsp_sum",   32'(bus.rsp_sum),   32'd0);
    chk("rst_rsp_flags", 32'({bus.rsp_cout, bus.rsp_ovfl, bus.rsp_zero}), 32'd0);
    chk("rst_cnt0",      32'(bus.gnt_cnt0),  32'd0);
    chk("rst_cnt1",      32'(bus.gnt_cnt1),  32'd0);
    chk("rst_add_a",     32'(bus.add_a),     32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single port-0 add
    cycle(1, 5, 3, 0, 0, 0, 0, 0, 1);
    chk("t1_sum",  32'(bus.rsp_sum),  32'h0008);
    chk("t1_id",   32'(bus.rsp_id),   32'd0);
    chk("t1_zero", 32'(bus.rsp_zero), 32'd0);
    chk("t1_cnt0", 32'(bus.gnt_cnt0), 32'd1);

    // Contention alternates; port 0 went last so port 1 leads
    exp_ids = '{1, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      cycle(1, $urandom_range(0, MODV - 1), $urandom_range(0, MODV - 1), 1'($urandom_range(0, 1)),
            1, $urandom_range(0, MODV - 1), $urandom_range(0, MODV - 1), 1'($urandom_range(0, 1)), 1);
      chk("alt_id", 32'(bus.rsp_id), 32'(exp_ids[i]));
    end
    chk("alt_cnt0", 32'(bus.gnt_cnt0), 32'd3);
    chk("alt_cnt1", 32'(bus.gnt_cnt1), 32'd2);

    // Signed overflow, then subtract to zero
    cycle(0, 0, 0, 0, 1, 16'h7FFF, 16'h0001, 0, 1);
    chk("ovf_sum",  32'(bus.rsp_sum),  32'h8000);
    chk("ovf_flag", 32'(bus.rsp_ovfl), 32'd1);
    cycle(0, 0, 0, 0, 1, 4, 4, 1, 1);
    chk("sub_zero", 32'(bus.rsp_zero), 32'd1);
    chk("sub_sum",  32'(bus.rsp_sum),  32'd0);
    chk("sub_cout", 32'(bus.rsp_cout), 32'd1);

    // Backpressure holds the buffer and blocks port 0
    for (int i = 0; i < 3; i++) begin
      cycle(1, 16'h1234, 16'h0101, 0, 0, 0, 0, 0, 0);
      chk("bp_sum",  32'(bus.rsp_sum),  32'd0);
      chk("bp_zero", 32'(bus.rsp_zero), 32'd1);
      chk("bp_id",   32'(bus.rsp_id),   32'd1);
    end
    cycle(1, 16'h1234, 16'h0101, 0, 0, 0, 0, 0, 1);
    chk("bp_new_sum", 32'(bus.rsp_sum), 32'h1335);
    chk("bp_new_id",  32'(bus.rsp_id),  32'd0);

    // Asynchronous reset between edges while the buffer is full
    @(negedge clk);
    drive(1, 1, 1, 0, 1, 2, 2, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("arst_cnt0",      32'(bus.gnt_cnt0),  32'd0);
    chk("arst_cnt1",      32'(bus.gnt_cnt1),  32'd0);
    chk("arst_rsp_sum",   32'(bus.rsp_sum),   32'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    cycle(1, 10, 20, 0, 1, 30, 40, 0, 1);
    chk("arst_first_id", 32'(bus.rsp_id),   32'd0);
    chk("arst_cnt0_one", 32'(bus.gnt_cnt0), 32'd1);

    // Counter saturation
    for (int i = 0; i < 300; i++) begin
      cycle(1, $urandom_range(0, MODV - 1), $urandom_range(0, MODV - 1), 1'($urandom_range(0, 1)),
            0, 0, 0, 0, 1);
    end
    chk("sat_cnt0", 32'(bus.gnt_cnt0), 32'd255);

    // Randomized traffic; blocked requesters hold their operands
    pend0 = 0; pend1 = 0;
    a0 = 0; b0 = 0; s0 = 0; a1 = 0; b1 = 0; s1 = 0; v0 = 0; v1 = 0;
    for (int i = 0; i < 300; i++) begin
      if (!pend0) begin
        v0 = 1'($urandom_range(0, 1));
        a0 = int'($urandom_range(0, MODV - 1));
        b0 = int'($urandom_range(0, MODV - 1));
        s0 = 1'($urandom_range(0, 1));
      end
      if (!pend1) begin
        v1 = 1'($urandom_range(0, 1));
        a1 = int'($urandom_range(0, MODV - 1));
        b1 = int'($urandom_range(0, MODV - 1));
        s1 = 1'($urandom_range(0, 1));
      end
      rr = ($urandom_range(0, 3) != 0);
      cycle(v0, a0, b0, s0, v1, a1, b1, s1, rr);
      pend0 = v0 && !(last_acc && last_sel == 0);
      pend1 = v1 && !(last_acc && last_sel == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
